// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, control field types and bubble constants shared by the control pipeline
package ctrl_pkg;
  localparam logic [6:0] OP_NOP   = 7'b0000000;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {IMM_I = 3'b000, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_t;
  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM, RES_PC4, RES_IMM} result_src_t;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB, ALU_FUNCT} alu_op_t;

  typedef struct packed {
    logic        reg_write;
    imm_src_t    imm_src;
    logic        alu_src;
    logic        alu_a_pc;
    logic        mem_write;
    result_src_t result_src;
    logic        branch;
    alu_op_t     alu_op;
    logic        jump;
    logic        jalr;
  } ctrl_t;

  // E stage drops imm_src (consumed in D) and carries the illegal flag instead
  typedef struct packed {
    logic        illegal;
    logic        reg_write;
    logic        alu_src;
    logic        alu_a_pc;
    logic        mem_write;
    result_src_t result_src;
    logic        branch;
    alu_op_t     alu_op;
    logic        jump;
    logic        jalr;
  } ctrl_e_t;

  localparam ctrl_t   CTRL_BUBBLE = '0;
  localparam ctrl_e_t E_BUBBLE    = '0;

  function automatic ctrl_e_t to_e(input ctrl_t c, input logic ill);
    return '{illegal: ill, reg_write: c.reg_write, alu_src: c.alu_src, alu_a_pc: c.alu_a_pc,
             mem_write: c.mem_write, result_src: c.result_src, branch: c.branch,
             alu_op: c.alu_op, jump: c.jump, jalr: c.jalr};
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode to control-word table with illegal detection
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit EN_JALR  = 1'b1,
  parameter bit EN_UPPER = 1'b1
) (
  input  logic [6:0] op,
  output ctrl_t      ctrl,
  output logic       illegal
);
  always_comb begin
    ctrl = CTRL_BUBBLE;
    illegal = 1'b0;
    case (op)
      OP_NOP:   ;
      OP_LW:    ctrl = '{1'b1, IMM_I, 1'b1, 1'b0, 1'b0, RES_MEM, 1'b0, ALU_ADD, 1'b0, 1'b0};
      OP_SW:    ctrl = '{1'b0, IMM_S, 1'b1, 1'b0, 1'b1, RES_ALU, 1'b0, ALU_ADD, 1'b0, 1'b0};
      OP_R:     ctrl = '{1'b1, IMM_I, 1'b0, 1'b0, 1'b0, RES_ALU, 1'b0, ALU_FUNCT, 1'b0, 1'b0};
      OP_BEQ:   ctrl = '{1'b0, IMM_B, 1'b0, 1'b0, 1'b0, RES_ALU, 1'b1, ALU_SUB, 1'b0, 1'b0};
      OP_IALU:  ctrl = '{1'b1, IMM_I, 1'b1, 1'b0, 1'b0, RES_ALU, 1'b0, ALU_FUNCT, 1'b0, 1'b0};
      OP_JAL:   ctrl = '{1'b1, IMM_J, 1'b0, 1'b0, 1'b0, RES_PC4, 1'b0, ALU_ADD, 1'b1, 1'b0};
      OP_JALR:
        if (EN_JALR) ctrl = '{1'b1, IMM_I, 1'b1, 1'b0, 1'b0, RES_PC4, 1'b0, ALU_ADD, 1'b1, 1'b1};
        else illegal = 1'b1;
      OP_LUI:
        if (EN_UPPER) ctrl = '{1'b1, IMM_U, 1'b0, 1'b0, 1'b0, RES_IMM, 1'b0, ALU_ADD, 1'b0, 1'b0};
        else illegal = 1'b1;
      OP_AUIPC:
        if (EN_UPPER) ctrl = '{1'b1, IMM_U, 1'b1, 1'b1, 1'b0, RES_ALU, 1'b0, ALU_ADD, 1'b0, 1'b0};
        else illegal = 1'b1;
      default:  illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: decodes in D and carries control bits through E/M/W with stall, flush,
// branch redirect and a saturating count of retired illegal instructions
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter bit EN_JALR  = 1'b1,
  parameter bit EN_UPPER = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op_code_d,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic             zero_e,
  output logic [2:0]       imm_src_d,
  output logic             illegal_d,
  output logic             alu_src_e,
  output logic             alu_a_pc_e,
  output logic [1:0]       alu_op_e,
  output logic [1:0]       result_src_e,
  output logic             pc_src_e,
  output logic             jalr_e,
  output logic             reg_write_m,
  output logic             mem_write_m,
  output logic [1:0]       result_src_m,
  output logic             reg_write_w,
  output logic [1:0]       result_src_w,
  output logic [CNT_W-1:0] ill_cnt
);
  ctrl_t       dec_c;
  logic        dec_ill;
  ctrl_e_t     e_d, e_q;
  logic        rw_m_d, rw_m_q, mw_m_d, mw_m_q, ill_m_d, ill_m_q;
  result_src_t rs_m_d, rs_m_q, rs_w_q;
  logic        rw_w_q, ill_w_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  ctrl_decode #(.EN_JALR(EN_JALR), .EN_UPPER(EN_UPPER)) u_dec (
    .op(op_code_d), .ctrl(dec_c), .illegal(dec_ill)
  );

  always_comb begin
    e_d = flush_e ? E_BUBBLE : stall_e ? e_q : to_e(dec_c, dec_ill);
    rw_m_d = ~stall_e & e_q.reg_write;
    mw_m_d = ~stall_e & e_q.mem_write;
    ill_m_d = ~stall_e & e_q.illegal;
    rs_m_d = stall_e ? RES_ALU : e_q.result_src;
    cnt_d = (ill_w_q && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= E_BUBBLE;
      rw_m_q <= 1'b0;
      mw_m_q <= 1'b0;
      ill_m_q <= 1'b0;
      rs_m_q <= RES_ALU;
      rw_w_q <= 1'b0;
      ill_w_q <= 1'b0;
      rs_w_q <= RES_ALU;
      cnt_q <= '0;
    end else begin
      e_q <= e_d;
      rw_m_q <= rw_m_d;
      mw_m_q <= mw_m_d;
      ill_m_q <= ill_m_d;
      rs_m_q <= rs_m_d;
      rw_w_q <= rw_m_q;
      ill_w_q <= ill_m_q;
      rs_w_q <= rs_m_q;
      cnt_q <= cnt_d;
    end
  end

  assign imm_src_d    = dec_c.imm_src;
  assign illegal_d    = dec_ill;
  assign alu_src_e    = e_q.alu_src;
  assign alu_a_pc_e   = e_q.alu_a_pc;
  assign alu_op_e     = e_q.alu_op;
  assign result_src_e = e_q.result_src;
  // redirect only on the cycle the instruction actually leaves E
  assign pc_src_e     = ((e_q.branch & zero_e) | e_q.jump) & ~stall_e;
  assign jalr_e       = e_q.jalr;
  assign reg_write_m  = rw_m_q;
  assign mem_write_m  = mw_m_q;
  assign result_src_m = rs_m_q;
  assign reg_write_w  = rw_w_q;
  assign result_src_w = rs_w_q;
  assign ill_cnt      = cnt_q;
endmodule
